// File: rtl/mul_pkg.sv
// Shared definitions for the FP multiplier back end: status bit positions,
// quiet-NaN mantissa bit, and the exponent overflow test.
package mul_pkg;

  localparam int EXPO_W_DEF = 8;
  localparam int MANT_W_DEF = 23;

  localparam int ST_NV = 4;
  localparam int ST_DZ = 3;
  localparam int ST_OF = 2;
  localparam int ST_UF = 1;
  localparam int ST_NX = 0;

  localparam logic [MANT_W_DEF-1:0] QNAN_BIT = MANT_W_DEF'(1) << (MANT_W_DEF - 1);

  // expo is an (ew+2)-bit two's complement exponent, zero-extended to 32 bits.
  // Overflow when non-negative and the low ew+1 bits reach the all-ones exponent.
  function automatic logic ovf_chk(input logic [31:0] expo, input int unsigned ew);
    logic [31:0] sh;
    logic [31:0] mag;
    logic [31:0] lim;
    sh  = expo >> (ew + 32'd1);
    mag = expo & ((32'd1 << (ew + 32'd1)) - 32'd1);
    lim = (32'd1 << ew) - 32'd1;
    return ~sh[0] & (mag >= lim);
  endfunction

endpackage

// File: rtl/mul_nan_sel.sv
// Special-result sign and mantissa: 0xInf canonical NaN, then A NaN, then B NaN
// (both quieted), otherwise infinity with the product sign. Purely combinational.
module mul_nan_sel #(
  parameter int MANT_W = 23
) (
  input  logic              r_0nan,
  input  logic              a_nan,
  input  logic              b_nan,
  input  logic              a_sign,
  input  logic              b_sign,
  input  logic              sign_1,
  input  logic [MANT_W-1:0] a_mant,
  input  logic [MANT_W-1:0] b_mant,
  output logic              sign_nan,
  output logic [MANT_W-1:0] mant_nan
);

  localparam logic [MANT_W-1:0] QNAN = MANT_W'(1) << (MANT_W - 1);

  always_comb begin
    sign_nan = sign_1;
    mant_nan = '0;
    if (r_0nan) begin
      sign_nan = 1'b0;
      mant_nan = QNAN;
    end else if (a_nan) begin
      sign_nan = a_sign;
      mant_nan = a_mant | QNAN;
    end else if (b_nan) begin
      sign_nan = b_sign;
      mant_nan = b_mant | QNAN;
    end
  end

endmodule

// File: rtl/mul_excp_stage.sv
// Final FP multiplier stage: overflow detect, NaN/Inf select and {NV,DZ,OF,UF,NX}
// status, registered once (1-cycle latency, loads only on valid_i, reset wins).
module mul_excp_stage
  import mul_pkg::*;
#(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [EXPO_W+1:0] expo_2,
  input  logic [EXPO_W+1:0] expo_3,
  input  logic              sign_1,
  input  logic              a_sign,
  input  logic              b_sign,
  input  logic [EXPO_W-1:0] a_expo,
  input  logic [EXPO_W-1:0] b_expo,
  input  logic [MANT_W-1:0] a_mant,
  input  logic [MANT_W-1:0] b_mant,
  input  logic              a_nan,
  input  logic              b_nan,
  input  logic              r_nan,
  input  logic              r_0nan,
  input  logic              inf_nan,
  input  logic              a_n0,
  input  logic              b_n0,
  input  logic              a_is_nor,
  input  logic              b_is_nor,
  input  logic              status_nv,
  input  logic              underflow,
  input  logic              inexact_sft,
  input  logic              inexact_rnd,
  output logic              valid_o,
  output logic              overflow,
  output logic              sign_nan,
  output logic [MANT_W-1:0] mant_4,
  output logic [4:0]        status
);

  // Exponents are reserved for a future NaN-boxing check; r_nan is implied by the other flags.
  logic unused_ok;
  assign unused_ok = ^{a_expo, b_expo, r_nan};

  logic              ovf_d;
  logic              sign_d;
  logic [MANT_W-1:0] mant_d;
  logic [4:0]        status_d;
  logic              finite_nz;
  logic              inx_any;
  logic              both_sub;

  assign ovf_d = ~inf_nan & (ovf_chk(32'(expo_2), EXPO_W) | ovf_chk(32'(expo_3), EXPO_W));

  mul_nan_sel #(.MANT_W(MANT_W)) u_nan_sel (
    .r_0nan   (r_0nan),
    .a_nan    (a_nan),
    .b_nan    (b_nan),
    .a_sign   (a_sign),
    .b_sign   (b_sign),
    .sign_1   (sign_1),
    .a_mant   (a_mant),
    .b_mant   (b_mant),
    .sign_nan (sign_d),
    .mant_nan (mant_d)
  );

  // Inf, NaN and zero results are exact, so only finite nonzero products raise OF/UF/NX.
  assign finite_nz = ~inf_nan & a_n0 & b_n0;
  assign inx_any   = inexact_sft | inexact_rnd;
  assign both_sub  = ~a_is_nor & ~b_is_nor;

  always_comb begin
    status_d        = '0;
    status_d[ST_NV] = status_nv;
    status_d[ST_DZ] = 1'b0;
    status_d[ST_OF] = finite_nz & ovf_d;
    status_d[ST_UF] = finite_nz & ((underflow & inx_any) | both_sub);
    status_d[ST_NX] = finite_nz & (ovf_d | inx_any | both_sub);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_o  <= 1'b0;
      overflow <= 1'b0;
      sign_nan <= 1'b0;
      mant_4   <= '0;
      status   <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        overflow <= ovf_d;
        sign_nan <= sign_d;
        mant_4   <= mant_d;
        status   <= status_d;
      end
    end
  end

endmodule

// File: tb/tb_mul_excp_stage.sv
// Scoreboard bench for mul_excp_stage: directed vectors push expected results,
// a negedge monitor pops on valid_o and checks reset and hold behaviour otherwise.
module tb_mul_excp_stage;

  typedef struct packed {
    logic [9:0]  expo_2;
    logic [9:0]  expo_3;
    logic        sign_1;
    logic        a_sign;
    logic        b_sign;
    logic [22:0] a_mant;
    logic [22:0] b_mant;
    logic        a_nan;
    logic        b_nan;
    logic        r_nan;
    logic        r_0nan;
    logic        inf_nan;
    logic        a_n0;
    logic        b_n0;
    logic        a_is_nor;
    logic        b_is_nor;
    logic        status_nv;
    logic        underflow;
    logic        inexact_sft;
    logic        inexact_rnd;
  } vin_t;

  typedef struct packed {
    logic        ovf;
    logic        sgn;
    logic [22:0] mant;
    logic [4:0]  st;
  } vexp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [9:0]  expo_2 = '0, expo_3 = '0;
  logic        sign_1 = 0, a_sign = 0, b_sign = 0;
  logic [7:0]  a_expo = 8'h7f, b_expo = 8'h80;
  logic [22:0] a_mant = '0, b_mant = '0;
  logic        a_nan = 0, b_nan = 0, r_nan = 0, r_0nan = 0, inf_nan = 0;
  logic        a_n0 = 0, b_n0 = 0, a_is_nor = 0, b_is_nor = 0;
  logic        status_nv = 0, underflow = 0, inexact_sft = 0, inexact_rnd = 0;
  logic        valid_o, overflow, sign_nan;
  logic [22:0] mant_4;
  logic [4:0]  status;

  int n_chk  = 0;
  int n_pass = 0;
  vexp_t exp_q[$];
  string name_q[$];
  vexp_t last_exp = '0;
  logic  rst_q = 1'b0;

  always #5 clk = ~clk;

  mul_excp_stage #(.EXPO_W(8), .MANT_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
    .expo_2(expo_2), .expo_3(expo_3), .sign_1(sign_1),
    .a_sign(a_sign), .b_sign(b_sign), .a_expo(a_expo), .b_expo(b_expo),
    .a_mant(a_mant), .b_mant(b_mant), .a_nan(a_nan), .b_nan(b_nan),
    .r_nan(r_nan), .r_0nan(r_0nan), .inf_nan(inf_nan),
    .a_n0(a_n0), .b_n0(b_n0), .a_is_nor(a_is_nor), .b_is_nor(b_is_nor),
    .status_nv(status_nv), .underflow(underflow),
    .inexact_sft(inexact_sft), .inexact_rnd(inexact_rnd),
    .valid_o(valid_o), .overflow(overflow), .sign_nan(sign_nan),
    .mant_4(mant_4), .status(status)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  task automatic chk_out(input string nm, input vexp_t e);
    chk({nm, ".overflow"}, 32'(overflow), 32'(e.ovf));
    chk({nm, ".sign_nan"}, 32'(sign_nan), 32'(e.sgn));
    chk({nm, ".mant_4"},   32'(mant_4),   32'(e.mant));
    chk({nm, ".status"},   32'(status),   32'(e.st));
  endtask

  always @(posedge clk) rst_q <= rst_n;

  always @(negedge clk) begin
    if (!rst_q) begin
      chk("reset.valid_o", 32'(valid_o), 32'd0);
      chk_out("reset", '0);
      last_exp = '0;
    end else if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid_o", 32'd1, 32'd0);
      end else begin
        last_exp = exp_q.pop_front();
        chk_out(name_q.pop_front(), last_exp);
      end
    end else begin
      chk("idle.valid_o", 32'(valid_o), 32'd0);
      chk_out("hold", last_exp);
    end
  end

  function automatic vin_t base();
    vin_t v;
    v = '0;
    v.expo_2 = 10'h080;
    v.expo_3 = 10'h080;
    v.a_n0 = 1'b1;
    v.b_n0 = 1'b1;
    v.a_is_nor = 1'b1;
    v.b_is_nor = 1'b1;
    return v;
  endfunction

  function automatic vexp_t mk(input logic o, input logic s, input logic [22:0] m, input logic [4:0] st);
    vexp_t e;
    e.ovf = o; e.sgn = s; e.mant = m; e.st = st;
    return e;
  endfunction

  task automatic drive(input vin_t v, input logic vld, input logic rst);
    @(posedge clk);
    #1;
    rst_n = rst; valid_i = vld;
    expo_2 = v.expo_2; expo_3 = v.expo_3; sign_1 = v.sign_1;
    a_sign = v.a_sign; b_sign = v.b_sign; a_mant = v.a_mant; b_mant = v.b_mant;
    a_nan = v.a_nan; b_nan = v.b_nan; r_nan = v.r_nan; r_0nan = v.r_0nan;
    inf_nan = v.inf_nan; a_n0 = v.a_n0; b_n0 = v.b_n0;
    a_is_nor = v.a_is_nor; b_is_nor = v.b_is_nor; status_nv = v.status_nv;
    underflow = v.underflow; inexact_sft = v.inexact_sft; inexact_rnd = v.inexact_rnd;
  endtask

  task automatic send(input string nm, input vin_t v, input vexp_t e);
    drive(v, 1'b1, 1'b1);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(base(), 1'b0, 1'b1);
  endtask

  initial begin
    vin_t v;
    drive(base(), 1'b1, 1'b0);
    drive(base(), 1'b0, 1'b0);
    drive(base(), 1'b0, 1'b0);

    v = base(); v.expo_3 = 10'h0FF; v.expo_2 = 10'h0FE;
    send("ovf_boundary", v, mk(1, 0, 23'h0, 5'b00101));
    v = base(); v.expo_3 = 10'h3FF; v.expo_2 = 10'h3FF; v.sign_1 = 1;
    send("ovf_negative", v, mk(0, 1, 23'h0, 5'b00000));
    v = base(); v.expo_2 = 10'h0FF; v.expo_3 = 10'h0FE;
    send("ovf_pre_round", v, mk(1, 0, 23'h0, 5'b00101));
    v = base(); v.expo_2 = 10'h200; v.expo_3 = 10'h100;
    send("ovf_large", v, mk(1, 0, 23'h0, 5'b00101));
    v = base(); v.expo_3 = 10'h0FE; v.expo_2 = 10'h0FE; v.inexact_rnd = 1;
    send("no_ovf_254", v, mk(0, 0, 23'h0, 5'b00001));
    v = base(); v.expo_3 = 10'h0FF; v.inf_nan = 1;
    send("ovf_masked_inf", v, mk(0, 0, 23'h0, 5'b00000));
    v = base(); v.r_0nan = 1; v.r_nan = 1; v.inf_nan = 1; v.status_nv = 1; v.a_sign = 1; v.sign_1 = 1;
    send("zero_x_inf", v, mk(0, 0, 23'h400000, 5'b10000));
    v = base(); v.a_nan = 1; v.a_sign = 1; v.a_mant = 23'h000001; v.r_nan = 1; v.inf_nan = 1; v.status_nv = 1;
    send("snan_a", v, mk(0, 1, 23'h400001, 5'b10000));
    v = base(); v.b_nan = 1; v.b_sign = 1; v.b_mant = 23'h123456; v.r_nan = 1; v.inf_nan = 1;
    send("nan_b", v, mk(0, 1, 23'h523456, 5'b00000));
    v = base(); v.a_nan = 1; v.b_nan = 1; v.a_mant = 23'h400ABC; v.b_sign = 1; v.b_mant = 23'h0000FF;
    v.r_nan = 1; v.inf_nan = 1;
    send("nan_both", v, mk(0, 0, 23'h400ABC, 5'b00000));
    v = base(); v.inf_nan = 1; v.sign_1 = 1; v.expo_3 = 10'h0FF;
    send("inf", v, mk(0, 1, 23'h0, 5'b00000));
    v = base(); v.underflow = 1; v.inexact_sft = 1;
    send("tiny_inexact", v, mk(0, 0, 23'h0, 5'b00011));
    v = base(); v.underflow = 1;
    send("tiny_exact", v, mk(0, 0, 23'h0, 5'b00000));
    v = base(); v.a_n0 = 0; v.inexact_rnd = 1;
    send("zero_operand", v, mk(0, 0, 23'h0, 5'b00000));
    v = base(); v.a_is_nor = 0; v.b_is_nor = 0;
    send("both_subnormal", v, mk(0, 0, 23'h0, 5'b00011));
    v = base(); v.a_is_nor = 0; v.inexact_rnd = 1;
    send("one_subnormal", v, mk(0, 0, 23'h0, 5'b00001));
    v = base(); v.expo_3 = 10'h0FF; v.inexact_rnd = 1; v.sign_1 = 1;
    send("ovf_inexact", v, mk(1, 1, 23'h0, 5'b00101));

    idle(3);

    v = base(); v.a_nan = 1; v.a_sign = 1; v.a_mant = 23'h0ABCDE; v.inf_nan = 1; v.status_nv = 1;
    send("pre_reset", v, mk(0, 1, 23'h4ABCDE, 5'b10000));
    v = base(); v.expo_3 = 10'h0FF; v.inexact_sft = 1;
    drive(v, 1'b1, 1'b0);
    idle(2);
    v = base(); v.underflow = 1; v.inexact_rnd = 1; v.sign_1 = 1;
    send("post_reset", v, mk(0, 1, 23'h0, 5'b00011));
    idle(2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
